// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// FSM state enum, opcode constants, ALUOp and ALUControl codes.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format selected purely by opcode; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return 2'b01;
      OP_BRANCH: return 2'b10;
      OP_JAL:    return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function fields to ALUControl.
module alu_decoder
  import mc_control_fsm_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi never subtracts, even when imm[10] happens to be set
          3'b000:  ALUControl = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM with memory-ready stalls, one-shot store
// strobe and an illegal-opcode trap state that holds until reset.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic       wr_done_q, wr_done_d;
  logic       mem_ok;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] alu_op;

  assign mem_ok = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  always_comb begin
    state_d   = state_q;
    wr_done_d = 1'b0;
    pc_write  = 1'b0;
    adr_src   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write  = mem_ok;
        pc_write  = mem_ok;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        // Write strobe only on the first cycle; later stall cycles just wait.
        adr_src   = 1'b1;
        mem_write = ~wr_done_q;
        wr_done_d = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        alu_op   = ALUOP_SUB;
        pc_write = zero;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_done_q <= wr_done_d;
    end
  end

  alu_decoder u_alu_decoder (
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (alu_op),
    .ALUControl (ALUControl)
  );

  // Strobes are masked while reset is sampled low, including a pending store.
  assign PCWrite       = pc_write  & reset;
  assign AdrSrc        = adr_src;
  assign MemWrite      = mem_write & reset;
  assign IRWrite       = ir_write  & reset;
  assign RegWrite      = reg_write & reset;
  assign illegal_instr = illegal   & reset;
  assign ImmSrc        = imm_src_of(op);
  assign state         = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm with hand-computed expectations.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal_instr;
  logic [3:0] state;

  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_pulses;
  int rw_pulses;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_HANDSHAKE(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ImmSrc        (ImmSrc),
    .ALUControl    (ALUControl),
    .illegal_instr (illegal_instr),
    .state         (state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs FETCH and DECODE; returns one cycle into the third state.
  task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, input int imm);
    op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
    #1;
    chk("fetch_state", state, 0);
    chk("fetch_irwrite", IRWrite, 1);
    chk("fetch_pcwrite", PCWrite, 1);
    chk("fetch_srcb", ALUSrcB, 2);
    chk("fetch_result", ResultSrc, 2);
    tick(); #1;
    chk("decode_state", state, 1);
    chk("decode_imm", ImmSrc, imm);
    chk("decode_srca", ALUSrcA, 1);
    chk("decode_srcb", ALUSrcB, 1);
    chk("decode_regwrite", RegWrite, 0);
    tick();
  endtask

  task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input int exp_ctrl, input int exp_state, input int exp_srcb);
    fetch_decode(o, f3, f7, 0);
    #1;
    chk("exec_state", state, exp_state);
    chk("exec_aluctl", ALUControl, exp_ctrl);
    chk("exec_srca", ALUSrcA, 2);
    chk("exec_srcb", ALUSrcB, exp_srcb);
    chk("exec_regwrite", RegWrite, 0);
    tick(); #1;
    chk("aluwb_state", state, 8);
    chk("aluwb_regwrite", RegWrite, 1);
    chk("aluwb_result", ResultSrc, 0);
    tick(); #1;
    chk("aluwb_next", state, 0);
  endtask

  initial begin
    reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    tick(); tick(); #1;
    chk("rst_state", state, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_illegal", illegal_instr, 0);
    reset = 1'b1;

    // ALU ops: add, sub, addi with f7b5 set, and, ori, slt
    run_alu(7'b0110011, 3'b000, 1'b0, 0, 6, 0);
    run_alu(7'b0110011, 3'b000, 1'b1, 1, 6, 0);
    run_alu(7'b0010011, 3'b000, 1'b1, 0, 7, 1);
    run_alu(7'b0110011, 3'b111, 1'b0, 2, 6, 0);
    run_alu(7'b0010011, 3'b110, 1'b0, 3, 7, 1);
    run_alu(7'b0110011, 3'b010, 1'b0, 5, 6, 0);

    // Fetch stall
    mem_ready = 1'b0; #1;
    chk("fstall_irwrite", IRWrite, 0);
    chk("fstall_pcwrite", PCWrite, 0);
    tick(); #1;
    chk("fstall_state", state, 0);

    // Load with two stall cycles in MEMREAD
    rw_pulses = 0;
    fetch_decode(7'b0000011, 3'b010, 1'b0, 0);
    #1;
    chk("lw_memadr", state, 2);
    chk("lw_memadr_srca", ALUSrcA, 2);
    rw_pulses += int'(RegWrite);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      chk("lw_memread", state, 3);
      chk("lw_adrsrc", AdrSrc, 1);
      rw_pulses += int'(RegWrite);
      tick();
    end
    #1;
    chk("lw_memwb", state, 4);
    chk("lw_memwb_result", ResultSrc, 1);
    chk("lw_memwb_regwrite", RegWrite, 1);
    rw_pulses += int'(RegWrite);
    tick(); #1;
    chk("lw_next", state, 0);
    chk("lw_regwrite_pulses", rw_pulses, 1);

    // Store with three stall cycles in MEMWRITE
    wr_pulses = 0;
    fetch_decode(7'b0100011, 3'b010, 1'b0, 1);
    #1;
    chk("sw_memadr", state, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      chk("sw_memwrite_state", state, 5);
      if (i == 0) chk("sw_first_memwrite", MemWrite, 1);
      wr_pulses += int'(MemWrite);
      tick();
    end
    #1;
    chk("sw_next", state, 0);
    chk("sw_memwrite_pulses", wr_pulses, 1);

    // beq taken then not taken
    fetch_decode(7'b1100011, 3'b000, 1'b0, 2);
    zero = 1'b1; #1;
    chk("beq_state", state, 9);
    chk("beq_taken_pcwrite", PCWrite, 1);
    chk("beq_aluctl", ALUControl, 1);
    tick(); #1;
    chk("beq_next", state, 0);
    fetch_decode(7'b1100011, 3'b000, 1'b0, 2);
    zero = 1'b0; #1;
    chk("beq_nt_pcwrite", PCWrite, 0);
    tick();

    // jal
    fetch_decode(7'b1101111, 3'b000, 1'b0, 3);
    #1;
    chk("jal_state", state, 10);
    chk("jal_pcwrite", PCWrite, 1);
    chk("jal_srca", ALUSrcA, 1);
    chk("jal_srcb", ALUSrcB, 2);
    tick(); #1;
    chk("jal_aluwb", state, 8);
    chk("jal_regwrite", RegWrite, 1);
    tick();

    // Reset during EXECUTER
    fetch_decode(7'b0110011, 3'b000, 1'b0, 0);
    reset = 1'b0; #1;
    chk("rexec_state", state, 6);
    chk("rexec_regwrite", RegWrite, 0);
    tick(); #1;
    chk("rexec_next", state, 0);
    chk("rexec_regwrite2", RegWrite, 0);
    reset = 1'b1;

    // Reset on the first MEMWRITE cycle
    fetch_decode(7'b0100011, 3'b010, 1'b0, 1);
    tick();
    reset = 1'b0; mem_ready = 1'b0; #1;
    chk("rmw_state", state, 5);
    chk("rmw_memwrite", MemWrite, 0);
    tick(); #1;
    chk("rmw_next", state, 0);
    reset = 1'b1;

    // Illegal opcode trap
    fetch_decode(7'b1111111, 3'b000, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("ill_state", state, 11);
      chk("ill_flag", illegal_instr, 1);
      chk("ill_pcwrite", PCWrite, 0);
      chk("ill_regwrite", RegWrite, 0);
      chk("ill_memwrite", MemWrite, 0);
      tick();
    end
    reset = 1'b0; #1;
    chk("ill_rst_flag", illegal_instr, 0);
    tick(); #1;
    chk("ill_rst_state", state, 0);
    reset = 1'b1; mem_ready = 1'b1; #1;
    chk("ill_refetch_irwrite", IRWrite, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, SHALL gate mem_ready: when 0, mem_ready is ignored and treated as 1.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be synchronous and active-low.
REQ-004 op  in  7  SHALL carry the instruction opcode from the instruction register.
REQ-005 funct3  in  3; funct7b5  in  1  SHALL carry the instruction function fields.
REQ-006 zero  in  1  SHALL carry the ALU zero flag.
REQ-007 mem_ready  in  1  SHALL indicate memory access completion.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  SHALL be datapath strobes/selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each; ALUControl  out  3  SHALL be datapath selects.
REQ-010 illegal_instr  out  1; state  out  4  SHALL give trap status and current state for debug.

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL.
REQ-012 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00(PC), ALUSrcB=10(+4), ALUControl=add, ResultSrc=10, PCWrite=1; on mem_ready go DECODE; otherwise hold with IRWrite=PCWrite=0.
REQ-013 DECODE: ALUSrcA=01(OldPC), ALUSrcB=01(imm), ALUControl=add; next state by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, any other->ILLEGAL.
REQ-014 MEMADR: ALUSrcA=10, ALUSrcB=01, add; op 0000011->MEMREAD, else->MEMWRITE.
REQ-015 MEMREAD: ResultSrc=00, AdrSrc=1; on mem_ready->MEMWB, else hold.
REQ-016 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 for exactly one cycle per store (first cycle in state); on mem_ready->FETCH, else hold with MemWrite=0.
REQ-017 MEMWB: ResultSrc=01, RegWrite=1 ->FETCH.
REQ-018 EXECUTER/EXECUTEI: ALUSrcA=10, ALUSrcB=00/01, ALUControl from decode ->ALUWB.
REQ-019 ALUWB: ResultSrc=00, RegWrite=1 ->FETCH.
REQ-020 BEQ: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00, PCWrite=zero ->FETCH.
REQ-021 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 ->ALUWB.
REQ-022 ILLEGAL: illegal_instr=1, all write strobes 0; SHALL hold until reset.
REQ-023 ALUControl encoding SHALL be add=000, sub=001, and=010, or=011, slt=101; funct3 000 gives sub only when op=0110011 and funct7b5=1.
REQ-024 ImmSrc SHALL be combinational from op: I=00, S=01, B=10, J=11; don't-care ops drive 00.
REQ-025 In every state, strobes not listed SHALL be 0; selects not listed SHALL be 00.
REQ-026 Latency: R/I-type 4 cycles, load 5, store 4, beq 3, jal 4, plus stall cycles.

Reset
REQ-027 reset low at a clock edge SHALL force FETCH with all strobes 0 and illegal_instr=0, overriding any stall or ILLEGAL.
REQ-028 Reset mid-MEMWRITE SHALL suppress MemWrite in the cycle reset is sampled.

Structure
REQ-029 A shared package SHALL hold the state enum, opcode constants and ALUControl codes.
REQ-030 One sub-module, alu_decoder (op, funct3, funct7b5, ALUOp -> ALUControl), SHALL be instantiated.

Verification
REQ-031 add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1 -> FETCH,DECODE,EXECUTER,ALUWB; ALUControl=000; RegWrite=1 only in ALUWB.
REQ-032 lw with mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles; RegWrite=1 once in MEMWB.
REQ-033 beq, zero=1 then zero=0 -> PCWrite=1 in BEQ only for first; ALUControl=001.
REQ-034 sw with mem_ready low 3 cycles -> MemWrite=1 for exactly one cycle.
REQ-035 op=1111111 -> ILLEGAL, illegal_instr=1, held 10 cycles; reset low -> FETCH.
REQ-036 reset low during EXECUTER -> next state FETCH, RegWrite never asserted.
